onehot_demux4_router: RTL and testbench

//  Inverse of the codebase's one-hot 4:1 word selector: steers one 32-bit input word to one of

---
 rtl/onehot_demux4_router.sv | 91 +++++++++
 tb/tb_onehot_demux4_router.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_demux4_router.sv
// rtl/onehot_demux4_router.sv - one-hot select 1:4 word router with per-channel 1-entry output registers
module onehot_demux4_router #(
    parameter int W     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic [3:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data1,
    output logic [W-1:0]     out_data2,
    output logic [W-1:0]     out_data3,
    output logic [W-1:0]     out_data4,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    input  logic             err_clr,
    output logic             sel_err,
    output logic [CNT_W-1:0] drop_count
);

    // Channel registers indexed by select bit position: bit3 = ch1 .. bit0 = ch4.
    logic [W-1:0]     data_q [4];
    logic [3:0]       valid_q, valid_d;
    logic             sel_err_q, sel_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       sel_legal;
    logic       accept;
    logic       bad_accept;
    logic [3:0] push;
    logic [3:0] pop;

    assign sel_legal = (in_sel != 4'b0000) && ((in_sel & (in_sel - 4'd1)) == 4'b0000);

    // A malformed select is always taken so it can be dropped without stalling the producer.
    always_comb begin
        in_ready = 1'b1;
        if (sel_legal) begin
            in_ready = |(in_sel & (~valid_q | out_ready));
        end
    end

    assign accept     = in_valid & in_ready;
    assign bad_accept = accept & ~sel_legal;
    assign push       = (accept & sel_legal) ? in_sel : 4'b0000;
    assign pop        = valid_q & out_ready;
    assign valid_d    = (valid_q & ~pop) | push;

    // Clear takes effect before a same-cycle drop is counted.
    always_comb begin
        cnt_d     = err_clr ? '0 : cnt_q;
        sel_err_d = err_clr ? 1'b0 : sel_err_q;
        if (bad_accept) begin
            sel_err_d = 1'b1;
            if (!(&cnt_d)) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 4'b0000;
            sel_err_q <= 1'b0;
            cnt_q     <= '0;
            for (int j = 0; j < 4; j++) begin
                data_q[j] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            sel_err_q <= sel_err_d;
            cnt_q     <= cnt_d;
            for (int j = 0; j < 4; j++) begin
                if (push[j]) begin
                    data_q[j] <= in_data;
                end
            end
        end
    end

    assign out_data1  = data_q[3];
    assign out_data2  = data_q[2];
    assign out_data3  = data_q[1];
    assign out_data4  = data_q[0];
    assign out_valid  = valid_q;
    assign sel_err    = sel_err_q;
    assign drop_count = cnt_q;

endmodule

// File: tb/tb_onehot_demux4_router.sv
// tb/tb_onehot_demux4_router.sv - randomized and directed self-checking bench for onehot_demux4_router
module tb_onehot_demux4_router;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic [3:0]  in_sel = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  out_ready = '0;
    logic        err_clr = 1'b0;

    logic        in_ready;
    logic [31:0] out_data1, out_data2, out_data3, out_data4;
    logic [3:0]  out_valid;
    logic        sel_err;
    logic [7:0]  drop_count;

    logic        in_ready_b;
    logic [31:0] out_data1_b, out_data2_b, out_data3_b, out_data4_b;
    logic [3:0]  out_valid_b;
    logic        sel_err_b;
    logic [1:0]  drop_count_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 1'b0;

    always #5 clk = ~clk;

    onehot_demux4_router #(.W(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data1(out_data1), .out_data2(out_data2),
        .out_data3(out_data3), .out_data4(out_data4), .out_valid(out_valid),
        .out_ready(out_ready), .err_clr(err_clr), .sel_err(sel_err), .drop_count(drop_count)
    );

    onehot_demux4_router #(.W(32), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready_b), .out_data1(out_data1_b), .out_data2(out_data2_b),
        .out_data3(out_data3_b), .out_data4(out_data4_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .err_clr(err_clr), .sel_err(sel_err_b), .drop_count(drop_count_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: channel c (1..4) holds at most one word; drops counted without bound.
    bit          m_full [1:4];
    logic [31:0] m_word [1:4];
    bit          m_err;
    int          m_drops;

    function automatic int sel_channel(input logic [3:0] s);
        if ($countones(s) != 1) return 0;
        for (int c = 1; c <= 4; c++) begin
            if (s[4 - c]) return c;
        end
        return 0;
    endfunction

    function automatic bit model_ready(input logic [3:0] s, input logic [3:0] rdy);
        int c;
        c = sel_channel(s);
        if (c == 0) return 1'b1;
        return !m_full[c] || rdy[4 - c];
    endfunction

    always @(negedge clk) begin
        int  c;
        bit  rdy;
        if (rst) begin
            for (int i = 1; i <= 4; i++) begin
                m_full[i] = 1'b0;
                m_word[i] = '0;
            end
            m_err   = 1'b0;
            m_drops = 0;
        end
        if (run) begin
            rdy = model_ready(in_sel, out_ready);
            check("in_ready", in_ready, rdy);
            check("in_ready_b", in_ready_b, rdy);
            check("out_valid", out_valid, {m_full[1], m_full[2], m_full[3], m_full[4]});
            check("out_data1", out_data1, m_word[1]);
            check("out_data2", out_data2, m_word[2]);
            check("out_data3", out_data3, m_word[3]);
            check("out_data4", out_data4, m_word[4]);
            check("sel_err", sel_err, m_err);
            check("drop_count", drop_count, (m_drops > 255) ? 255 : m_drops);
            check("sel_err_b", sel_err_b, m_err);
            check("drop_count_b", drop_count_b, (m_drops > 3) ? 3 : m_drops);
            if (!rst) begin
                c = sel_channel(in_sel);
                for (int i = 1; i <= 4; i++) begin
                    if (m_full[i] && out_ready[4 - i]) m_full[i] = 1'b0;
                end
                if (err_clr) begin
                    m_err   = 1'b0;
                    m_drops = 0;
                end
                if (in_valid && rdy) begin
                    if (c != 0) begin
                        m_full[c] = 1'b1;
                        m_word[c] = in_data;
                    end else begin
                        m_err   = 1'b1;
                        m_drops = m_drops + 1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 4'b0000);
        check("reset_in_ready", in_ready, 1'b1);

        // Single word to ch2, visible for exactly one cycle.
        out_ready = 4'hF;
        drive(1'b1, 4'b0100, 32'hDEADBEEF);
        step();
        drive(1'b0, 4'b0100, 32'h0);
        #1;
        check("t2_valid", out_valid, 4'b0100);
        check("t2_data2", out_data2, 32'hDEADBEEF);
        step();
        #1;
        check("t2_valid_after", out_valid, 4'b0000);

        // Ch1 stall then simultaneous pop and push.
        out_ready = 4'b0111;
        drive(1'b1, 4'b1000, 32'h1);
        step();
        drive(1'b1, 4'b1000, 32'h2);
        #1;
        check("t3_ready_low", in_ready, 1'b0);
        check("t3_data1_held", out_data1, 32'h1);
        step();
        #1;
        check("t3_still_held", out_data1, 32'h1);
        out_ready = 4'hF;
        #1;
        check("t3_ready_high", in_ready, 1'b1);
        step();
        drive(1'b0, 4'b0000, 32'h0);
        #1;
        check("t3_data1_new", out_data1, 32'h2);
        check("t3_valid_kept", out_valid[3], 1'b1);
        step();
        #1;
        check("t3_valid_clear", out_valid[3], 1'b0);

        // Malformed selects dropped and counted, then cleared.
        drive(1'b1, 4'b0000, 32'h11);
        #1;
        check("t4_ready_zero", in_ready, 1'b1);
        step();
        drive(1'b1, 4'b1100, 32'h22);
        #1;
        check("t4_ready_multi", in_ready, 1'b1);
        step();
        drive(1'b0, 4'b0000, 32'h0);
        #1;
        check("t4_valid", out_valid, 4'b0000);
        check("t4_err", sel_err, 1'b1);
        check("t4_count", drop_count, 8'd2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #1;
        check("t4_err_clr", sel_err, 1'b0);
        check("t4_count_clr", drop_count, 8'd0);

        // Saturation on the narrow counter; clear plus drop in the same cycle.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b1111, i);
            step();
        end
        drive(1'b0, 4'b0000, 32'h0);
        #1;
        check("t5_sat_b", drop_count_b, 2'd3);
        check("t5_count", drop_count, 8'd5);
        err_clr = 1'b1;
        drive(1'b1, 4'b0110, 32'h33);
        step();
        err_clr = 1'b0;
        drive(1'b0, 4'b0000, 32'h0);
        #1;
        check("t5_clr_drop_b", drop_count_b, 2'd1);
        check("t5_clr_err_b", sel_err_b, 1'b1);
        check("t5_clr_drop", drop_count, 8'd1);

        // Ch1 stalled full while ch4 streams back-to-back.
        out_ready = 4'b0111;
        drive(1'b1, 4'b1000, 32'hA5A5A5A5);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b0001, 32'hC000 + i);
            step();
            #1;
            check("t6_data4", out_data4, 32'hC000 + i);
            check("t6_valid4", out_valid[0], 1'b1);
        end
        drive(1'b0, 4'b0000, 32'h0);
        step();
        #1;
        check("t6_ch1_held", out_data1, 32'hA5A5A5A5);
        check("t6_ch1_valid", out_valid[3], 1'b1);

        // Async reset with ch1 and ch3 held.
        out_ready = 4'b0000;
        drive(1'b1, 4'b0010, 32'h5555);
        step();
        drive(1'b0, 4'b0000, 32'h0);
        #1;
        check("t1_pre_valid", out_valid, 4'b1010);
        rst = 1'b1;
        #1;
        check("t1_valid", out_valid, 4'b0000);
        check("t1_data1", out_data1, 32'h0);
        check("t1_data3", out_data3, 32'h0);
        check("t1_err", sel_err, 1'b0);
        check("t1_count", drop_count, 8'd0);
        step();
        rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 7);
            in_sel    = (r < 6) ? (4'b0001 << (r % 4)) : 4'($urandom_range(0, 15));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = 4'($urandom_range(0, 15));
            err_clr   = ($urandom_range(0, 15) == 0);
            step();
        end

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
